// File: rtl/decode_stage.sv
// Decode stage: one IF/ID register, field decode, load-use hazard detection
// with a one-cycle bubble, branch flush, and a saturating stall counter.
module decode_stage #(
  parameter int IWIDTH = 24,
  parameter int PWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IWIDTH-1:0] instr_i,
  input  logic [PWIDTH-1:0] pc_i,
  input  logic              flush_i,
  input  logic              ex_load_i,
  input  logic [3:0]        ex_rd_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [3:0]        opcode_o,
  output logic [3:0]        rd_o,
  output logic [3:0]        rs1_o,
  output logic [3:0]        rs2_o,
  output logic [PWIDTH-1:0] imm_o,
  output logic [PWIDTH-1:0] pc_o,
  output logic [15:0]       stall_cnt_o
);

  logic [IWIDTH-1:0] instr_reg;
  logic [PWIDTH-1:0] pc_reg;
  logic              id_valid_reg;
  logic [15:0]       stall_cnt_reg;
  logic              hazard;
  logic              reads_rs2;

  assign opcode_o    = instr_reg[23:20];
  assign rd_o        = instr_reg[19:16];
  assign rs1_o       = instr_reg[15:12];
  assign rs2_o       = instr_reg[11:8];
  assign imm_o       = {{(PWIDTH-8){instr_reg[7]}}, instr_reg[7:0]};
  assign pc_o        = pc_reg;
  assign stall_cnt_o = stall_cnt_reg;

  // Opcodes with bit 3 set use the rs2 field as immediate bits, not a source.
  assign reads_rs2 = ~instr_reg[23];
  assign hazard    = id_valid_reg & ex_load_i & (ex_rd_i != 4'd0) &
                     ((ex_rd_i == rs1_o) | (reads_rs2 & (ex_rd_i == rs2_o)));

  assign stall_o = hazard & ~flush_i;
  assign valid_o = id_valid_reg & ~flush_i & ~hazard;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_reg     <= '0;
      pc_reg        <= '0;
      id_valid_reg  <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (flush_i) begin
        instr_reg    <= instr_i;
        pc_reg       <= pc_i;
        id_valid_reg <= 1'b0;
      end else if (!stall_o) begin
        instr_reg    <= instr_i;
        pc_reg       <= pc_i;
        id_valid_reg <= 1'b1;
      end
      if (stall_o && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, hazards, flush, saturation, reset.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [23:0] instr_i;
  logic [15:0] pc_i;
  logic        flush_i;
  logic        ex_load_i;
  logic [3:0]  ex_rd_i;
  logic        stall_o;
  logic        valid_o;
  logic [3:0]  opcode_o, rd_o, rs1_o, rs2_o;
  logic [15:0] imm_o, pc_o, stall_cnt_o;

  int errors = 0;
  int checks = 0;

  decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
    .flush_i(flush_i), .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
    .stall_o(stall_o), .valid_o(valid_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o),
    .pc_o(pc_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("ok   %s obs=%0h", tag, obs);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; instr_i = '0; pc_i = '0; flush_i = 1'b0;
    ex_load_i = 1'b0; ex_rd_i = '0;
    #3;
    check("rst_valid", valid_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_opcode", opcode_o, 0);
    check("rst_imm", imm_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_cnt", stall_cnt_o, 0);
    step();
    step();

    rst_i = 1'b1; instr_i = 24'h312305; pc_i = 16'h0001;
    step();
    check("dec_valid", valid_o, 1);
    check("dec_opcode", opcode_o, 3);
    check("dec_rd", rd_o, 1);
    check("dec_rs1", rs1_o, 2);
    check("dec_rs2", rs2_o, 3);
    check("dec_imm", imm_o, 16'h0005);
    check("dec_pc", pc_o, 16'h0001);

    // rs1 load-use hazard
    instr_i = 24'h1452F0; pc_i = 16'h0002;
    step();
    check("lu_imm_neg", imm_o, 16'hFFF0);
    instr_i = 24'h9A0780; pc_i = 16'h0003;
    ex_load_i = 1'b1; ex_rd_i = 4'd5;
    #1;
    check("lu_stall", stall_o, 1);
    check("lu_bubble", valid_o, 0);
    step();
    check("lu_hold_op", opcode_o, 1);
    check("lu_hold_rs1", rs1_o, 5);
    check("lu_hold_rs2", rs2_o, 2);
    check("lu_hold_pc", pc_o, 16'h0002);
    check("lu_cnt", stall_cnt_o, 1);
    ex_load_i = 1'b0;
    #1;
    check("lu_release_valid", valid_o, 1);
    check("lu_release_stall", stall_o, 0);

    // opcode[3]=1: rs2 not a source
    step();
    check("op9_opcode", opcode_o, 9);
    check("op9_imm80", imm_o, 16'hFF80);
    ex_load_i = 1'b1; ex_rd_i = 4'd7;
    #1;
    check("op9_rs2_nostall", stall_o, 0);
    check("op9_rs2_valid", valid_o, 1);
    ex_rd_i = 4'd0;
    #1;
    check("op9_rd0_nostall", stall_o, 0);

    // rs2 hazard for opcode[3]=0, then flush overriding it
    ex_load_i = 1'b0;
    instr_i = 24'h21237F; pc_i = 16'h0005;
    step();
    check("imm7f", imm_o, 16'h007F);
    ex_load_i = 1'b1; ex_rd_i = 4'd3;
    #1;
    check("rs2_stall", stall_o, 1);
    flush_i = 1'b1;
    instr_i = 24'h534100; pc_i = 16'h0006;
    #1;
    check("flush_stall", stall_o, 0);
    check("flush_valid", valid_o, 0);
    step();
    flush_i = 1'b0;
    ex_rd_i = 4'd4;
    instr_i = 24'h645600; pc_i = 16'h0007;
    #1;
    check("flushed_valid", valid_o, 0);
    check("flushed_captured_op", opcode_o, 5);
    check("flushed_captured_pc", pc_o, 16'h0006);
    check("flushed_no_hazard", stall_o, 0);
    check("flush_cnt_unchanged", stall_cnt_o, 1);
    ex_load_i = 1'b0;
    step();
    check("post_flush_valid", valid_o, 1);
    check("post_flush_op", opcode_o, 6);

    // NOP never hazards on register 0
    instr_i = 24'h000000; pc_i = 16'h0008;
    step();
    ex_load_i = 1'b1; ex_rd_i = 4'd0;
    #1;
    check("nop_nostall", stall_o, 0);
    check("nop_valid", valid_o, 1);
    ex_load_i = 1'b0;
    instr_i = 24'h645600; pc_i = 16'h0009;
    step();

    // Saturation: hold the hazard for 65540 edges
    ex_load_i = 1'b1; ex_rd_i = 4'd5;
    repeat (65540) @(posedge clk_i);
    #1;
    check("sat_cnt", stall_cnt_o, 16'hFFFF);
    check("sat_stall", stall_o, 1);
    check("sat_hold_pc", pc_o, 16'h0009);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_cnt", stall_cnt_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_stall", stall_o, 0);
    check("arst_opcode", opcode_o, 0);
    step();
    ex_load_i = 1'b0;
    instr_i = 24'h312305; pc_i = 16'h0001;
    rst_i = 1'b1;
    step();
    check("rerel_valid", valid_o, 1);
    check("rerel_opcode", opcode_o, 3);
    check("rerel_pc", pc_o, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
